// File: rtl/sipo_piso_datapath.sv
// -----------------------------------------------------------------------------
// sipo_piso_datapath
//   Shift-register datapath for a serial link: a parallel-in/serial-out
//   transmit register and a serial-in/parallel-out receive register sharing
//   one bit counter. The external controller sequences load/shift/out; this
//   block only supplies the storage plus the last-bit indication (set_out).
//
// Configuration macro:
//   SIPO_PISO_DATAPATH_PARITY_EN - adds output 'parity', the XOR of the word
//                                  captured into dout, registered with it.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset, overrides all controls
//   load       in   tx_reg <= din, bit_cnt <= 0 (priority over shift)
//   shift      in   shift tx/rx registers one bit, advance bit_cnt
//   out        in   dout <= rx_reg (pre-edge value), dout_valid strobe
//   din        in   [WIDTH] parallel word to serialize
//   sin        in   serial receive bit
//   sout       out  serial transmit bit (tx_reg MSB, combinational)
//   set_out    out  high during the WIDTH-th shift cycle (combinational)
//   dout       out  [WIDTH] registered received word
//   dout_valid out  one-cycle strobe following an out cycle
//   parity     out  (macro only) XOR of captured dout
//   bit_cnt    out  [$clog2(WIDTH)] current shift count
// -----------------------------------------------------------------------------
module sipo_piso_datapath #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic                     shift,
   input  logic                     out,
   input  logic [WIDTH-1:0]         din,
   input  logic                     sin,
   output logic                     sout,
   output logic                     set_out,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
`ifdef SIPO_PISO_DATAPATH_PARITY_EN
   output logic                     parity,
`endif
   output logic [$clog2(WIDTH)-1:0] bit_cnt
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_tx;
   logic [WIDTH-1:0] r_rx;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_valid;
   logic [CW-1:0]    r_cnt;

   logic             w_shift_en;
   logic             w_last;

   // load wins over shift in the same cycle
   assign w_shift_en = shift & ~load;
   assign w_last     = (r_cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx         <= '0;
         r_rx         <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_cnt        <= '0;
      end else begin
         if (load) begin
            r_tx  <= din;
            r_cnt <= '0;
         end else if (shift) begin
            r_tx  <= {r_tx[WIDTH-2:0], 1'b0};
            r_rx  <= {r_rx[WIDTH-2:0], sin};
            // explicit wrap so non-power-of-two widths also return to 0
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
         end
         // out samples rx before any shift happening in the same cycle
         r_dout_valid <= out;
         if (out) begin
            r_dout <= r_rx;
         end
      end
   end

`ifdef SIPO_PISO_DATAPATH_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (out) begin
         r_parity <= ^r_rx;
      end
   end

   assign parity = r_parity;
`endif

   assign sout       = r_tx[WIDTH-1];
   assign set_out    = w_shift_en & w_last;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_sipo_piso_datapath.sv
// -----------------------------------------------------------------------------
// tb_sipo_piso_datapath
//   Self-checking bench for sipo_piso_datapath (WIDTH=8). A word-level model
//   (integers plus shift arithmetic) predicts every output; directed scenarios
//   plus a randomized run compare the DUT against it.
//   Define SIPO_PISO_DATAPATH_PARITY_EN to also exercise the parity output.
// -----------------------------------------------------------------------------
module tb_sipo_piso_datapath;

   localparam int W    = 8;
   localparam int CW   = $clog2(W);
   localparam int MASK = (1 << W) - 1;

   logic          clk;
   logic          rst;
   logic          load;
   logic          shift;
   logic          out;
   logic [W-1:0]  din;
   logic          sin;
   logic          sout;
   logic          set_out;
   logic [W-1:0]  dout;
   logic          dout_valid;
   logic [CW-1:0] bit_cnt;
`ifdef SIPO_PISO_DATAPATH_PARITY_EN
   logic          parity;
`endif

   int checks = 0;
   int errors = 0;

   // word-level reference model
   int unsigned m_tx;
   int unsigned m_rx;
   int unsigned m_dout;
   int unsigned m_cnt;
   bit          m_dv;
   bit          m_par;

   sipo_piso_datapath #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .shift      (shift),
      .out        (out),
      .din        (din),
      .sin        (sin),
      .sout       (sout),
      .set_out    (set_out),
      .dout       (dout),
      .dout_valid (dout_valid),
`ifdef SIPO_PISO_DATAPATH_PARITY_EN
      .parity     (parity),
`endif
      .bit_cnt    (bit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit exp_sout();
      return bit'((m_tx >> (W - 1)) & 1);
   endfunction

   function automatic bit exp_set_out();
      return shift && !load && (m_cnt == W - 1);
   endfunction

   // drive inputs and let combinational outputs settle
   task automatic set_in(input bit l, input bit s, input bit o,
                         input logic [W-1:0] d, input bit si);
      load  = l;
      shift = s;
      out   = o;
      din   = d;
      sin   = si;
      #1;
   endtask

   // clock edge plus model update from the pre-edge inputs and state
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_tx = 0; m_rx = 0; m_dout = 0; m_cnt = 0; m_dv = 0; m_par = 0;
      end else begin
         m_dv = out;
         if (out) begin
            m_dout = m_rx;
            m_par  = bit'($countones(m_rx) % 2);
         end
         if (load) begin
            m_tx  = din;
            m_cnt = 0;
         end else if (shift) begin
            m_tx  = (m_tx << 1) & MASK;
            m_rx  = ((m_rx << 1) | sin) & MASK;
            m_cnt = (m_cnt + 1) % W;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(0, 0, 0, '0, 0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      // reset with every control asserted must still clear everything
      rst = 1'b1;
      set_in(1, 1, 1, W'($urandom), 1);
      tick();
      rst = 1'b0;
      set_in(0, 0, 0, '0, 0);
      checks++;
      if (bit_cnt !== '0 || sout !== 1'b0 || dout !== '0 || dout_valid !== 1'b0 ||
          set_out !== 1'b0) begin
         errors++;
         $display("FAIL reset: cnt=%0d sout=%0b dout=%h dv=%0b set_out=%0b, want all 0",
                  bit_cnt, sout, dout, dout_valid, set_out);
      end
   endtask

   task automatic test_a5_loopback();
      logic [W-1:0] word;
      word = 8'hA5;
      set_in(1, 0, 0, word, 0);
      tick();
      for (int i = 0; i < W; i++) begin
         set_in(0, 1, 0, '0, exp_sout());
         checks++;
         if (sout !== word[W-1-i]) begin
            errors++;
            $display("FAIL a5_sout[%0d]: got %0b want %0b", i, sout, word[W-1-i]);
         end
         checks++;
         if (set_out !== (i == W - 1)) begin
            errors++;
            $display("FAIL a5_set_out[%0d]: got %0b want %0b", i, set_out, (i == W - 1));
         end
         tick();
      end
      set_in(0, 0, 1, '0, 0);
      tick();
      set_in(0, 0, 0, '0, 0);
      checks++;
      if (dout !== word || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL a5_dout: got %h/%0b want %h/1", dout, dout_valid, word);
      end
      tick();
      checks++;
      if (dout_valid !== 1'b0 || dout !== word) begin
         errors++;
         $display("FAIL a5_hold: got %h/%0b want %h/0", dout, dout_valid, word);
      end
   endtask

   task automatic test_load_priority();
      // park counter on last position so a shift would raise set_out
      set_in(1, 0, 0, 8'hFF, 0);
      tick();
      for (int i = 0; i < W - 1; i++) begin
         set_in(0, 1, 0, '0, 0);
         tick();
      end
      set_in(1, 1, 0, 8'h3C, 1);
      checks++;
      if (set_out !== 1'b0) begin
         errors++;
         $display("FAIL prio_set_out: got %0b want 0", set_out);
      end
      tick();
      set_in(0, 0, 0, '0, 0);
      checks++;
      if (bit_cnt !== '0 || sout !== 1'b0) begin
         errors++;
         $display("FAIL prio_after: cnt=%0d sout=%0b want 0/0", bit_cnt, sout);
      end
      // tx must hold 3C: shift it out and compare against the constant
      for (int i = 0; i < W; i++) begin
         logic [W-1:0] v;
         v = 8'h3C;
         set_in(0, 1, 0, '0, 0);
         checks++;
         if (sout !== v[W-1-i]) begin
            errors++;
            $display("FAIL prio_tx[%0d]: got %0b want %0b", i, sout, v[W-1-i]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_transfer();
      set_in(1, 0, 0, 8'hFF, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 1, 0, '0, 1);
         tick();
      end
      do_reset();
      set_in(0, 0, 0, '0, 0);
      checks++;
      if (bit_cnt !== '0 || sout !== 1'b0 || dout !== '0 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst: cnt=%0d sout=%0b dout=%h dv=%0b want 0",
                  bit_cnt, sout, dout, dout_valid);
      end
      for (int i = 0; i < W; i++) begin
         set_in(0, 1, 0, '0, 1'($urandom));
         checks++;
         if (set_out !== (i == W - 1)) begin
            errors++;
            $display("FAIL midrst_set_out[%0d]: got %0b want %0b", i, set_out, (i == W - 1));
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      set_in(1, 0, 0, W'($urandom), 0);
      tick();
      for (int i = 0; i < 2 * W; i++) begin
         set_in(0, 1, 0, '0, 1'($urandom));
         checks++;
         if (set_out !== (i == W - 1 || i == 2 * W - 1)) begin
            errors++;
            $display("FAIL wrap_set_out[%0d]: got %0b", i, set_out);
         end
         tick();
         if (i == W - 1 || i == 2 * W - 1) begin
            checks++;
            if (bit_cnt !== '0) begin
               errors++;
               $display("FAIL wrap_cnt[%0d]: got %0d want 0", i, bit_cnt);
            end
         end
      end
   endtask

   task automatic test_out_after_reset();
      do_reset();
      set_in(0, 0, 1, '0, 0);
      tick();
      set_in(0, 0, 0, '0, 0);
      checks++;
      if (dout !== '0 || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL out_rst: got %h/%0b want 00/1", dout, dout_valid);
      end
      tick();
      checks++;
      if (dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL out_rst_strobe: got %0b want 0", dout_valid);
      end
   endtask

   task automatic test_out_with_shift();
      logic [W-1:0] word;
      word = W'($urandom);
      set_in(1, 0, 0, word, 0);
      tick();
      for (int i = 0; i < W; i++) begin
         set_in(0, 1, 0, '0, exp_sout());
         tick();
      end
      // out together with a further shift: the captured word predates it
      set_in(0, 1, 1, '0, 1'($urandom));
      tick();
      set_in(0, 0, 0, '0, 0);
      checks++;
      if (dout !== word || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL out_shift: got %h/%0b want %h/1", dout, dout_valid, word);
      end
   endtask

`ifdef SIPO_PISO_DATAPATH_PARITY_EN
   task automatic test_parity();
      logic [W-1:0] words [2];
      bit           want  [2];
      words[0] = 8'hA5; want[0] = 1'b0;
      words[1] = 8'h07; want[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         set_in(1, 0, 0, words[k], 0);
         tick();
         for (int i = 0; i < W; i++) begin
            set_in(0, 1, 0, '0, exp_sout());
            tick();
         end
         set_in(0, 0, 1, '0, 0);
         tick();
         set_in(0, 0, 0, '0, 0);
         checks++;
         if (parity !== want[k] || dout !== words[k]) begin
            errors++;
            $display("FAIL parity_%h: got %0b/%h want %0b", words[k], parity, dout, want[k]);
         end
      end
      do_reset();
      checks++;
      if (parity !== 1'b0) begin
         errors++;
         $display("FAIL parity_reset: got %0b want 0", parity);
      end
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 29) == 0);
         set_in(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 5) == 0), W'($urandom), 1'($urandom));
         checks++;
         if (sout !== exp_sout() || set_out !== exp_set_out()) begin
            errors++;
            $display("FAIL rnd_comb[%0d]: sout=%0b set_out=%0b want %0b/%0b",
                     n, sout, set_out, exp_sout(), exp_set_out());
         end
         tick();
         checks++;
         if (dout !== W'(m_dout) || dout_valid !== m_dv || bit_cnt !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL rnd_reg[%0d]: dout=%h dv=%0b cnt=%0d want %h/%0b/%0d",
                     n, dout, dout_valid, bit_cnt, m_dout, m_dv, m_cnt);
         end
`ifdef SIPO_PISO_DATAPATH_PARITY_EN
         checks++;
         if (parity !== m_par) begin
            errors++;
            $display("FAIL rnd_parity[%0d]: got %0b want %0b", n, parity, m_par);
         end
`endif
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      m_tx = 0; m_rx = 0; m_dout = 0; m_cnt = 0; m_dv = 0; m_par = 0;
      set_in(0, 0, 0, '0, 0);
      test_reset();
      test_a5_loopback();
      test_load_priority();
      test_reset_mid_transfer();
      test_wrap();
      test_out_after_reset();
      test_out_with_shift();
`ifdef SIPO_PISO_DATAPATH_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sipo_piso_datapath.md
SIPO_PISO_DATAPATH -- requirements
Module: sipo_piso_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, word width in bits; legal range 2..32.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port load  input  1  capture din into the transmit register and clear the bit counter.
REQ-005 Port shift  input  1  shift the transmit and receive registers by one bit and advance the counter.
REQ-006 Port out  input  1  capture the receive register into dout.
REQ-007 Port din  input  WIDTH  parallel word to serialize.
REQ-008 Port sin  input  1  serial receive bit.
REQ-009 Port sout  output  1  serial transmit bit; equals the transmit register MSB.
REQ-010 Port set_out  output  1  last-bit indication to the controller.
REQ-011 Port dout  output  WIDTH  registered parallel received word.
REQ-012 Port dout_valid  output  1  one-cycle strobe marking dout update.
REQ-013 Port bit_cnt  output  $clog2(WIDTH)  current shift count.

Function
REQ-014 A cycle with load=1 SHALL set tx_reg<=din and bit_cnt<=0; the receive register is unchanged.
REQ-015 A cycle with shift=1 and load=0 SHALL perform tx_reg<={tx_reg[WIDTH-2:0],1'b0} and rx_reg<={rx_reg[WIDTH-2:0],sin}.
REQ-016 The same shift cycle SHALL increment bit_cnt; bit_cnt SHALL wrap from WIDTH-1 to 0.
REQ-017 The block SHALL transmit MSB first: sout=tx_reg[WIDTH-1] combinationally, so the bit presented during a shift cycle is the bit being sent.
REQ-018 set_out SHALL be combinational: shift && !load && (bit_cnt==WIDTH-1).
REQ-019 set_out SHALL therefore be high during exactly the WIDTH-th shift cycle, so a controller that drops shift one cycle after sampling set_out performs exactly WIDTH shifts.
REQ-020 A cycle with out=1 SHALL set dout<=rx_reg, using the pre-edge value, and dout_valid<=1.
REQ-021 dout_valid SHALL be 0 in every cycle not preceded by an out=1 cycle.
REQ-022 If load and shift are both 1 in the same cycle, load SHALL take priority: no shift occurs, bit_cnt<=0 and set_out=0.
REQ-023 out SHALL act independently of load and shift; when out and shift are both 1, dout captures rx_reg before that shift.
REQ-024 shift without a prior load SHALL shift the current tx_reg contents; no error is flagged.
REQ-025 dout SHALL hold its value until the next out cycle.
REQ-026 Latency: din is visible on sout in the cycle after load; a word shifted in is visible on dout in the cycle after out.

Reset
REQ-027 When rst=1 at a clock edge, tx_reg, rx_reg, dout and bit_cnt SHALL become 0 and dout_valid SHALL become 0.
REQ-028 As a result, sout=0 and set_out=0 after reset.
REQ-029 rst SHALL override load, shift and out in the same cycle.
REQ-030 Reset mid-transfer SHALL abandon the word; no partial dout_valid is produced.

Configuration
REQ-031 When macro SIPO_PISO_DATAPATH_PARITY_EN is defined, the block SHALL add output port parity (1 bit), registered alongside dout on each out cycle.
REQ-032 parity SHALL equal the XOR of the captured word and SHALL reset to 0.
REQ-033 When the macro is undefined, the parity port and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8, sin tied to sout)
REQ-034 Load din=8'hA5, then 8 shift cycles -> sout=1,0,1,0,0,1,0,1; set_out=1 only in the 8th cycle; out in the next cycle -> dout=8'hA5, dout_valid high for 1 cycle.
REQ-035 load=1 and shift=1 in the same cycle with din=8'h3C -> bit_cnt=0, set_out=0, sout=0 in the next cycle (tx_reg=8'h3C).
REQ-036 Load 8'hFF, 3 shifts, then rst=1 for 1 cycle -> bit_cnt=0, sout=0, dout=0, dout_valid=0; no set_out afterwards without 8 further shifts.
REQ-037 16 consecutive shifts after load -> set_out high at shifts 8 and 16 only; bit_cnt reads 0 after each wrap.
REQ-038 With SIPO_PISO_DATAPATH_PARITY_EN defined: transfer 8'hA5 -> parity=0; transfer 8'h07 -> parity=1.
REQ-039 out=1 asserted with no transfer after reset -> dout=8'h00 and dout_valid=1 for 1 cycle.
